// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the spoc reset sequencer.
// State encodings, reset polarity levels and counter widths.
package rst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    localparam int RUN_CNT_W = 32;
    localparam int RST_CNT_W = 16;

    function automatic logic [RST_CNT_W-1:0] sat_inc_rst(
        input logic [RST_CNT_W-1:0] v
    );
        return (&v) ? v : v + RST_CNT_W'(1);
    endfunction

    function automatic logic [RUN_CNT_W-1:0] sat_inc_run(
        input logic [RUN_CNT_W-1:0] v
    );
        return (&v) ? v : v + RUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rst_sequencer_sync.sv
// Reset synchroniser: asserts asynchronously, releases after
// SYNC_STAGES rising edges with rst high.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_n_sync
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: hold all domains, release them one by one,
// re-enter reset on software request or run-cycle limit.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGGER     = 2,
    parameter int RUN_LIMIT   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_rst_req,
    input  logic                 halt_i,
    output logic [NUM_CH-1:0]    ch_rst_o,
    output logic                 all_released_o,
    output logic [RUN_CNT_W-1:0] run_cnt_o,
    output logic [RST_CNT_W-1:0] reset_count_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);

    localparam bit LIMIT_EN = (RUN_LIMIT > 0);
    localparam logic [RUN_CNT_W-1:0] LIMIT_LAST =
        RUN_CNT_W'(LIMIT_EN ? RUN_LIMIT - 1 : 0);

    logic rst_n_sync;

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [STG_W-1:0]       stg_q, stg_d;
    logic [NUM_CH-1:0]      ch_q, ch_d, ch_shift;
    logic                   all_q, all_d;
    logic [RUN_CNT_W-1:0]   run_q, run_d;
    logic [RST_CNT_W-1:0]   rc_q, rc_d;
    logic                   rerst;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .rst_n_sync (rst_n_sync)
    );

    // Domains release low-index first; a zero shifts in per release.
    assign ch_shift = ch_q << 1;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= ST_ASSERT;
            hold_q  <= '0;
            stg_q   <= '0;
            ch_q    <= {NUM_CH{ENABLED}};
            all_q   <= 1'b0;
            run_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            ch_q    <= ch_d;
            all_q   <= all_d;
            run_q   <= run_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        ch_d    = ch_q;
        run_d   = run_q;
        rc_d    = rc_q;
        rerst   = 1'b0;

        unique case (state_q)
            ST_ASSERT: begin
                if (sw_rst_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    stg_d   = '0;
                    ch_d    = ch_shift;
                    state_d = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (sw_rst_req) begin
                    rerst = 1'b1;
                end else if (stg_q == STG_LAST) begin
                    stg_d = '0;
                    ch_d  = ch_shift;
                    if (ch_shift == '0) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    stg_d = stg_q + STG_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_rst_req ||
                    (LIMIT_EN && !halt_i && run_q == LIMIT_LAST)) begin
                    rerst = 1'b1;
                end else if (!halt_i) begin
                    run_d = sat_inc_run(run_q);
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        // Both triggers funnel here, so a coincident pair counts once.
        if (rerst) begin
            state_d = ST_ASSERT;
            hold_d  = '0;
            stg_d   = '0;
            ch_d    = {NUM_CH{ENABLED}};
            run_d   = '0;
            rc_d    = sat_inc_rst(rc_q);
        end

        all_d = (state_d == ST_RUN);
    end

    assign ch_rst_o       = ch_q;
    assign all_released_o = all_q;
    assign run_cnt_o      = run_q;
    assign reset_count_o  = rc_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: timeline reference model
// pushes per-edge expectations, a negedge monitor checks them.
module tb_rst_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 8;
    localparam int STG  = 2;
    localparam int LIM  = 50;
    localparam int SS   = 2;

    logic         clk        = 1'b1;
    logic         rst        = 1'b0;
    logic         sw_rst_req = 1'b0;
    logic         halt_i     = 1'b0;
    logic [N-1:0] ch_rst_o;
    logic         all_released_o;
    logic [31:0]  run_cnt_o;
    logic [15:0]  reset_count_o;

    typedef struct packed {
        logic [N-1:0] ch;
        logic         all;
        logic [31:0]  run;
        logic [15:0]  rc;
        logic [31:0]  eno;
    } exp_t;

    exp_t exp_q[$];

    int     n_checks = 0;
    int     n_fail   = 0;
    int     ecnt     = 0;
    int     start    = SS;
    longint run_m    = 0;
    int     rc_m     = 0;

    rst_sequencer #(
        .NUM_CH      (N),
        .HOLD_CYCLES (HOLD),
        .STAGGER     (STG),
        .RUN_LIMIT   (LIM),
        .SYNC_STAGES (SS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_rst_req     (sw_rst_req),
        .halt_i         (halt_i),
        .ch_rst_o       (ch_rst_o),
        .all_released_o (all_released_o),
        .run_cnt_o      (run_cnt_o),
        .reset_count_o  (reset_count_o)
    );

    always #5 clk = ~clk;

    // Model: 'start' is the edge at which the hold period began.
    function automatic void mreset();
        ecnt  = 0;
        start = SS;
        run_m = 0;
        rc_m  = 0;
    endfunction

    function automatic void mstep(input logic req, input logic hlt);
        int tp;
        bit rr;
        if (ecnt <= SS) return;
        tp = ecnt - 1 - start;
        rr = 1'b0;
        if (tp < HOLD) begin
            if (req) start = ecnt;
        end else if (tp < HOLD + (N - 1) * STG) begin
            if (req) rr = 1'b1;
        end else begin
            if (req || (!hlt && run_m == LIM - 1)) rr = 1'b1;
            else if (!hlt && run_m < 64'hFFFF_FFFF) run_m++;
        end
        if (rr) begin
            start = ecnt;
            run_m = 0;
            if (rc_m < 65535) rc_m++;
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        int t;
        t = ecnt - start;
        for (int k = 0; k < N; k++) e.ch[k] = (t < HOLD + k * STG);
        e.all = (t >= HOLD + (N - 1) * STG);
        e.run = run_m[31:0];
        e.rc  = 16'(rc_m);
        e.eno = 32'(ecnt);
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want, input logic [31:0] eno);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0h expected %0h",
                     nm, eno, got, want);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                mreset();
            end else begin
                ecnt++;
                mstep(sw_rst_req, halt_i);
            end
            push_exp();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ch_rst_o", 32'(ch_rst_o), 32'(e.ch), e.eno);
                chk("all_released_o", 32'(all_released_o),
                    32'(e.all), e.eno);
                chk("run_cnt_o", run_cnt_o, e.run, e.eno);
                chk("reset_count_o", 32'(reset_count_o),
                    32'(e.rc), e.eno);
            end
        end
    end

    task automatic goto_edge(input int n);
        while (ecnt < n - 1) @(negedge clk);
    endtask

    task automatic pulse_rst(input int low_cycles);
        @(posedge clk);
        #2;
        rst        = 1'b0;
        sw_rst_req = 1'b0;
        halt_i     = 1'b0;
        #1;
        exp_q.delete();
        mreset();
        push_exp();
        repeat (low_cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic sw_pulse(input int at_edge, input int len);
        goto_edge(at_edge);
        sw_rst_req = 1'b1;
        repeat (len) @(negedge clk);
        sw_rst_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #195;
        rst = 1'b1;
        goto_edge(82);

        pulse_rst(3);
        sw_pulse(30, 1);
        goto_edge(45);

        pulse_rst(3);
        sw_pulse(11, 1);
        goto_edge(25);

        pulse_rst(3);
        sw_pulse(64, 1);
        goto_edge(70);

        pulse_rst(3);
        goto_edge(20);
        halt_i = 1'b1;
        repeat (5) @(negedge clk);
        halt_i = 1'b0;
        goto_edge(80);

        pulse_rst(3);
        sw_pulse(5, 6);
        goto_edge(30);

        pulse_rst(2);
        goto_edge(40);
        pulse_rst(2);
        goto_edge(20);

        pulse_rst(2);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            halt_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 3) begin
                sw_rst_req = 1'b1;
                repeat ($urandom_range(1, 12)) @(negedge clk);
                sw_rst_req = 1'b0;
            end else begin
                sw_rst_req = ($urandom_range(0, 29) == 0);
            end
        end
        sw_rst_req = 1'b0;
        halt_i     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset sequencer for the `spoc` SoC. It synchronises the board-level asynchronous reset, holds all reset domains for a programmable time, then releases NUM_CH domains one after another. It re-enters reset on a software request or after a programmable run-cycle limit. It replaces fixed-time reset pulses with a synthesizable, cycle-exact sequence that both silicon and benches share.

## Interface
Parameters:
- NUM_CH, 3: number of reset domains; ≥1
- HOLD_CYCLES, 8: cycles all domains stay in reset after sequence start; ≥1
- STAGGER, 2: cycles between release of domain k and domain k+1; ≥1
- RUN_LIMIT, 0: RUN cycles before automatic re-reset; 0 disables it
- SYNC_STAGES, 2: reset synchroniser depth; ≥2

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- sw_rst_req  in  1  software reset request, sampled each edge
- halt_i  in  1  freezes the run counter while high
- ch_rst_o  out  NUM_CH  per-domain reset, active-high (`Enabled`)
- all_released_o  out  1  high while in RUN
- run_cnt_o  out  32  RUN cycles counted since last release
- reset_count_o  out  16  number of internal re-resets, saturating

## Operation
- The synchroniser asserts asynchronously on rst low. It deasserts after SYNC_STAGES edges with rst high.
- The FSM has three states:
  - ASSERT: all ch_rst_o high. hold_cnt counts edges from 0. At the edge where hold_cnt reaches HOLD_CYCLES, go to RELEASE and drop ch_rst_o[0].
  - RELEASE: stagger_cnt counts edges. ch_rst_o[k] drops k*STAGGER edges after ch_rst_o[0] drops. When ch_rst_o[NUM_CH-1] drops, go to RUN on that same edge. If NUM_CH=1, go straight from ASSERT to RUN.
  - RUN: all ch_rst_o low and all_released_o high. run_cnt increments on each edge with halt_i low, saturating at 0xFFFFFFFF.
- Re-reset triggers:
  - sw_rst_req high, in RUN or RELEASE: go to ASSERT on the next edge, all ch_rst_o high, hold_cnt=0, run_cnt=0.
  - RUN_LIMIT>0, in RUN, halt_i low, run_cnt==RUN_LIMIT-1: same action as sw_rst_req.
  - sw_rst_req in ASSERT: hold_cnt is held at 0. A held request keeps the block in reset.
- Simultaneous sw_rst_req and limit: one ASSERT entry, one increment of reset_count_o.
- reset_count_o increments on each entry to ASSERT from RUN or RELEASE. It saturates at 0xFFFF. Only rst clears it.
- Internal re-resets bypass the synchroniser; there is no SYNC_STAGES delay.

## Timing
- Reset values while rst is low (asynchronous):
  - ch_rst_o all 1s
  - all_released_o 0
  - run_cnt_o 0
  - reset_count_o 0
  - state ASSERT
- Edge 1 is the first rising edge after rst rises.
- Power-on release: ch_rst_o[k] falls at edge SYNC_STAGES + HOLD_CYCLES + k*STAGGER. all_released_o rises with the last channel.
- Internal re-reset: ch_rst_o goes all-high at the request edge E. ch_rst_o[k] falls at E + HOLD_CYCLES + k*STAGGER.
- All outputs are registered. There is no combinational path from sw_rst_req or halt_i to any output.
- rst low mid-sequence or mid-RUN forces the reset values immediately, without waiting for a clock edge.

## Structure
- define.vh: state encodings (ST_ASSERT, ST_RELEASE, ST_RUN), `Enabled`/`Disabled`, and the run/reset counter widths.
- Sub-module rst_sync:
  - parametrised SYNC_STAGES flop chain, asynchronously cleared, shifting in 1
  - output feeds the FSM
  - reused elsewhere for other domains
- Top level: FSM, hold/stagger counters sized $clog2(max+1), run and reset-event counters.

## Test plan
All scenarios use NUM_CH=3, HOLD_CYCLES=8, STAGGER=2, SYNC_STAGES=2, RUN_LIMIT=50 unless stated.
- Power-on: rst low for 195 ns, then high. Expect ch_rst_o=111 until edge 10, then 110 at edge 10, 100 at edge 12, 000 at edge 14. all_released_o rises at edge 14; run_cnt_o=1 after edge 15.
- Run limit: no stimulus after power-on. At edge 64, ch_rst_o=111 and reset_count_o=1. ch0 releases at edge 72, ch2 at edge 76.
- Software reset: one-cycle sw_rst_req sampled at edge 30 (RUN). Expect ch_rst_o=111 and run_cnt_o=0 at edge 30, reset_count_o=1, ch0 release at edge 38.
- Request during RELEASE: sw_rst_req at edge 11 (ch0 released, ch1 not). Expect ch_rst_o=111 at edge 11 and ch0 release at edge 19. A request coinciding with the limit edge increments reset_count_o by exactly 1.
- Halt: halt_i high for 5 cycles during RUN. Expect run_cnt_o frozen for those cycles and the limit re-reset moved from edge 64 to edge 69.
- Asynchronous reset mid-RUN: rst low between edges at around 40. Expect ch_rst_o=111, run_cnt_o=0, reset_count_o=0 before the next edge. After release the sequence repeats the power-on timing.
